// File: rtl/onehot_cell_encoder.sv
// One-hot cell-select encoder with a registered valid/ready output stage.
// Turns a WIDTH-bit cell word into index, row and column. It also flags
// all-zero and multi-hot words and keeps a saturating error count.

// One link of the priority chain: claims the win if no earlier bit was set.
module onehot_cell_lane (
  input  logic bit_in,
  input  logic seen_in,
  output logic hit,
  output logic dup,
  output logic seen_out
);
  assign hit      = bit_in & ~seen_in;
  assign dup      = bit_in & seen_in;
  assign seen_out = bit_in | seen_in;
endmodule

module onehot_cell_encoder #(
  parameter int WIDTH     = 36,
  parameter int COLS      = 6,
  parameter bit LSB_FIRST = 1'b1,
  parameter int ERR_CNT_W = 8,
  localparam int ROWS = (WIDTH + COLS - 1) / COLS,
  localparam int IW   = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH),
  localparam int RW   = ($clog2(ROWS)  < 1) ? 1 : $clog2(ROWS),
  localparam int CW   = ($clog2(COLS)  < 1) ? 1 : $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        out_index,
  output logic [RW-1:0]        out_row,
  output logic [CW-1:0]        out_col,
  output logic                 out_zero,
  output logic                 out_multi,
  output logic [ERR_CNT_W-1:0] err_count
);

  // seen[p] is set once any bit earlier in priority order is set.
  // The chain runs upward from bit 0 for LSB_FIRST and downward otherwise.
  logic [WIDTH:0]   seen;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] dup;

  assign seen[0] = 1'b0;

  for (genvar p = 0; p < WIDTH; p++) begin : g_lane
    localparam int B = LSB_FIRST ? p : (WIDTH - 1 - p);
    onehot_cell_lane u_lane (
      .bit_in   (in_data[B]),
      .seen_in  (seen[p]),
      .hit      (hit[B]),
      .dup      (dup[B]),
      .seen_out (seen[p+1])
    );
  end

  logic [IW-1:0] idx_nxt;
  logic [RW-1:0] row_nxt;
  logic [CW-1:0] col_nxt;
  logic          zero_nxt;
  logic          multi_nxt;
  logic          accept;
  logic          err_sat;

  // Encode the single winning bit, then split it into grid coordinates.
  always_comb begin
    idx_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (hit[i]) idx_nxt = idx_nxt | IW'(i);
    end
    row_nxt   = RW'(int'(idx_nxt) / COLS);
    col_nxt   = CW'(int'(idx_nxt) % COLS);
    zero_nxt  = ~seen[WIDTH];
    multi_nxt = |dup;
  end

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign err_sat  = &err_count;

  // Valid flag: set on accept, cleared when the consumer drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         out_valid <= 1'b0;
    else if (accept)    out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  // Result fields load only on accept and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_index <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_zero  <= 1'b0;
      out_multi <= 1'b0;
    end else if (accept) begin
      out_index <= idx_nxt;
      out_row   <= row_nxt;
      out_col   <= col_nxt;
      out_zero  <= zero_nxt;
      out_multi <= multi_nxt;
    end
  end

  // Saturating count of accepted zero-hot or multi-hot words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (accept && (zero_nxt || multi_nxt) && !err_sat)
      err_count <= err_count + 1'b1;
  end

endmodule
